ens_vote_argmax: RTL and testbench
==================================

// Module: ens_vote_argmax
// PURPOSE
//  Downstream of the final LUT layer of each ensemble member.
//  Accepts one class-score vector per ensemble member over a valid/ready stream and sums the scores per class.
//  After N_ENS members it runs a sequential argmax, one class per cycle.
//  It then holds the winning class and its summed score until the consumer accepts them.
// PARAMETERS
//  N_ENS    4   ensemble members per frame (>=1)
//  N_CLASS  10  classes per score vector (>=2)
//  SCORE_W  2   unsigned score bits per class from the final layer
//  ACC_W    SCORE_W+$clog2(N_ENS+1)  accumulator width (derived; cannot overflow)
//  CLS_W    $clog2(N_CLASS)          class index width (derived)
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               member score vector valid
//  in_ready   out  1               block can accept a member vector
//  in_scores  in   N_CLASS*SCORE_W class c at bits [c*SCORE_W +: SCORE_W]
//  out_valid  out  1               result valid
//  out_ready  in   1               consumer accepts result
//  out_class  out  CLS_W           winning class index
//  out_score  out  ACC_W           summed score of winning class
//  busy       out  1               high in ARGMAX or HOLD
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=ACCUM; all acc[c], member count, class index, best regs = 0.
//   - out_valid=0, out_class=0, out_score=0, in_ready=1, busy=0.
//   - Reset mid-frame or mid-argmax discards the partial frame.
//  FSM ACCUM -> ARGMAX -> HOLD -> ACCUM.
//  ACCUM:
//   - in_ready=1. On in_valid&in_ready: acc[c] <= acc[c] + slice c, zero-extended, for all c; cnt++.
//   - Gaps in in_valid are allowed; no timeout.
//   - Accept with cnt==N_ENS-1: cnt<=0, idx<=0, best_score<=0, best_class<=0, go to ARGMAX.
//  ARGMAX:
//   - in_ready=0. Each cycle: if acc[idx] > best_score (strict), then best_score<=acc[idx] and best_class<=idx.
//   - Strict compare means ties resolve to the lowest class index.
//   - idx==N_CLASS-1: go to HOLD, out_valid<=1, out_class/out_score <= final best (including class idx).
//   - out_valid rises exactly N_CLASS cycles after the edge that accepted the last member.
//  HOLD:
//   - out_valid=1, in_ready=0; out_class/out_score stable while out_ready=0.
//   - On out_ready: out_valid<=0, acc[*]<=0, go to ACCUM; in_ready=1 from the next cycle.
//   - in_valid during ARGMAX/HOLD is ignored, not accepted, and has no side effect.
//  out_ready outside HOLD is ignored.
//  Outputs are registered; no combinational in->out path except in_ready from state.
// TESTING
//  T1 N_ENS=4, SCORE_W=2: every member gives class3=3, others 0.
//     -> out_class=3, out_score=12, out_valid 10 cycles after the 4th accept.
//  T2 Totals class2=5, class7=5, others <5 -> out_class=2, out_score=5 (tie goes to lowest index).
//  T3 All-zero scores from all members -> out_class=0, out_score=0.
//  T4 Hold out_ready=0 for 20 cycles with in_valid=1.
//     -> outputs stable, in_ready=0, nothing accepted.
//     -> release: in_ready=1 the next cycle and accumulators restart from 0.
//  T5 Random 0-5 cycle gaps between member beats -> result identical to back-to-back delivery.
//  T6 Pulse rst_n low mid-ARGMAX -> immediately out_valid=0, in_ready=1.
//     -> the next full frame yields a correct result with no residue from the aborted frame.

Source files
------------

// File: rtl/ens_vote_argmax_if.sv
// Stream bundle for the ensemble vote block: member score vectors in, winning class out.
// The master side feeds scores and accepts results; the slave side is the voter.
interface ens_vote_argmax_if #(
  parameter int N_ENS   = 4,
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 2
);
  localparam int ACC_W = SCORE_W + $clog2(N_ENS + 1);
  localparam int CLS_W = $clog2(N_CLASS);

  logic                       in_valid;
  logic                       in_ready;
  logic [N_CLASS*SCORE_W-1:0] in_scores;
  logic                       out_valid;
  logic                       out_ready;
  logic [CLS_W-1:0]           out_class;
  logic [ACC_W-1:0]           out_score;
  logic                       busy;

  modport master (
    output in_valid, in_scores, out_ready,
    input  in_ready, out_valid, out_class, out_score, busy
  );

  modport slave (
    input  in_valid, in_scores, out_ready,
    output in_ready, out_valid, out_class, out_score, busy
  );
endinterface

// File: rtl/ens_vote_argmax.sv
// Sums per-class scores over N_ENS ensemble members, then scans the sums one class per cycle
// and holds the winning class and its score until the consumer takes them.
module ens_vote_argmax #(
  parameter int N_ENS   = 4,
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 2,
  parameter int ACC_W   = SCORE_W + $clog2(N_ENS + 1),
  parameter int CLS_W   = $clog2(N_CLASS)
) (
  input  logic               clk,
  input  logic               rst_n,
  ens_vote_argmax_if.slave   bus
);
  localparam int CNT_W = $clog2(N_ENS + 1);

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_ARGMAX = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] LAST_MEMBER = CNT_W'(N_ENS - 1);
  localparam logic [CLS_W-1:0] LAST_CLASS  = CLS_W'(N_CLASS - 1);

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc [N_CLASS];
  logic [CNT_W-1:0] r_cnt;
  logic [CLS_W-1:0] r_idx;
  logic [ACC_W-1:0] r_bestScore;
  logic [CLS_W-1:0] r_bestClass;
  logic             r_outValid;
  logic [CLS_W-1:0] r_outClass;
  logic [ACC_W-1:0] r_outScore;

  logic [ACC_W-1:0] w_accSel;
  logic             w_better;
  logic [ACC_W-1:0] w_nextScore;
  logic [CLS_W-1:0] w_nextClass;

  // Strict greater-than keeps the earliest class on ties.
  always_comb begin
    w_accSel    = r_acc[r_idx];
    w_better    = (w_accSel > r_bestScore);
    w_nextScore = w_better ? w_accSel : r_bestScore;
    w_nextClass = w_better ? r_idx    : r_bestClass;
  end

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.busy      = (r_state != ST_ACCUM);
  assign bus.out_valid = r_outValid;
  assign bus.out_class = r_outClass;
  assign bus.out_score = r_outScore;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_bestScore <= '0;
      r_bestClass <= '0;
      r_outValid  <= 1'b0;
      r_outClass  <= '0;
      r_outScore  <= '0;
      for (int c = 0; c < N_CLASS; c++) begin
        r_acc[c] <= '0;
      end
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            for (int c = 0; c < N_CLASS; c++) begin
              r_acc[c] <= r_acc[c] + {{(ACC_W-SCORE_W){1'b0}}, bus.in_scores[c*SCORE_W +: SCORE_W]};
            end
            if (r_cnt == LAST_MEMBER) begin
              r_cnt       <= '0;
              r_idx       <= '0;
              r_bestScore <= '0;
              r_bestClass <= '0;
              r_state     <= ST_ARGMAX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_ARGMAX: begin
          r_bestScore <= w_nextScore;
          r_bestClass <= w_nextClass;
          if (r_idx == LAST_CLASS) begin
            r_outValid <= 1'b1;
            r_outClass <= w_nextClass;
            r_outScore <= w_nextScore;
            r_state    <= ST_HOLD;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_HOLD: begin
          // Accumulators are cleared here so the next frame starts clean.
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= ST_ACCUM;
            for (int c = 0; c < N_CLASS; c++) begin
              r_acc[c] <= '0;
            end
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_ens_vote_argmax.sv
// Directed bench for ens_vote_argmax: hand-computed vote frames, tie-break, back-pressure,
// gapped delivery and a mid-scan reset.
module tb_ens_vote_argmax;
  localparam int N_ENS   = 4;
  localparam int N_CLASS = 10;
  localparam int SCORE_W = 2;
  localparam int VW      = N_CLASS * SCORE_W;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  ens_vote_argmax_if #(.N_ENS(N_ENS), .N_CLASS(N_CLASS), .SCORE_W(SCORE_W)) bus ();

  ens_vote_argmax #(.N_ENS(N_ENS), .N_CLASS(N_CLASS), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one member beat after an idle gap; returns on the negedge following acceptance.
  task automatic applyStimulus(input logic [VW-1:0] vec, input int gap);
    repeat (gap) @(negedge clk);
    checkOutput("in_ready_before_beat", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_scores = vec;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_scores = '0;
  endtask

  task automatic waitResult(input string tag, input int expClass, input int expScore);
    int cycles;
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd10);
    checkOutput({tag, "_class"}, 32'(bus.out_class), 32'(expClass));
    checkOutput({tag, "_score"}, 32'(bus.out_score), 32'(expScore));
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_scores = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_class", 32'(bus.out_class), 32'd0);
    checkOutput("rst_out_score", 32'(bus.out_score), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: class 3 gets 3 from every member -> 12
    $display("[TB] T1 single dominant class");
    for (int m = 0; m < N_ENS; m++) applyStimulus(20'h000C0, 0);
    waitResult("t1", 3, 12);
    consume("t1");

    // T2: totals c0=4 c2=5 c5=4 c7=5 c9=4 -> tie resolves to class 2
    $display("[TB] T2 tie break");
    applyStimulus(20'h08030, 0);
    applyStimulus(20'h0C021, 0);
    applyStimulus(20'hC0800, 0);
    applyStimulus(20'h40803, 0);
    waitResult("t2", 2, 5);
    consume("t2");

    $display("[TB] T3 all zero");
    for (int m = 0; m < N_ENS; m++) applyStimulus(20'h00000, 0);
    waitResult("t3", 0, 0);
    consume("t3");

    // T4: class 1 gets 2 per member -> 8; then long back-pressure with in_valid asserted
    $display("[TB] T4 back-pressure");
    for (int m = 0; m < N_ENS; m++) applyStimulus(20'h00008, 0);
    waitResult("t4", 1, 8);
    bus.in_valid  = 1'b1;
    bus.in_scores = 20'hFFFFF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    checkOutput("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t4_hold_class", 32'(bus.out_class), 32'd1);
    checkOutput("t4_hold_score", 32'(bus.out_score), 32'd8);
    bus.in_valid  = 1'b0;
    bus.in_scores = '0;
    consume("t4");

    // T5: T2 frame with random gaps -> same result; also proves accumulators restarted at 0
    $display("[TB] T5 gapped delivery");
    applyStimulus(20'h08030, $urandom_range(0, 5));
    applyStimulus(20'h0C021, $urandom_range(0, 5));
    applyStimulus(20'hC0800, $urandom_range(0, 5));
    applyStimulus(20'h40803, $urandom_range(0, 5));
    waitResult("t5", 2, 5);
    consume("t5");

    // T6: abort mid-scan with a frame favouring class 9, then a clean class 3 frame
    $display("[TB] T6 reset during argmax");
    for (int m = 0; m < N_ENS; m++) applyStimulus(20'hC0000, 0);
    repeat (4) @(negedge clk);
    checkOutput("t6_busy_mid_scan", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t6_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int m = 0; m < N_ENS; m++) applyStimulus(20'h000C0, 0);
    waitResult("t6", 3, 12);
    consume("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
